// File: rtl/table_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// table_writer : write engine for the RLECCA label tables (NEW / ADD / MERGE)
// Rev 1.0
// ---------------------------------------------------------------------------
module table_writer #(
  parameter int ADDRESS_BIT = 9,
  parameter int DATA_BIT    = 38,
  parameter int X_BIT       = 10,
  parameter int Y_BIT       = 9,
  parameter int EXTRA_BIT   = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_code,
  input  logic [ADDRESS_BIT-1:0] op_label,
  input  logic [ADDRESS_BIT-1:0] op_ha,
  input  logic [ADDRESS_BIT-1:0] op_hb,
  input  logic [ADDRESS_BIT-1:0] op_ta,
  input  logic [ADDRESS_BIT-1:0] op_tb,
  input  logic [DATA_BIT-1:0]    op_da,
  input  logic [DATA_BIT-1:0]    op_db,
  input  logic [EXTRA_BIT-1:0]   op_ea,
  input  logic [EXTRA_BIT-1:0]   op_eb,
  output logic [ADDRESS_BIT-1:0] w_raddr,
  input  logic [ADDRESS_BIT-1:0] w_rdata,
  output logic                   h_we,
  output logic                   t_we,
  output logic                   n_we,
  output logic                   d_we,
  output logic [ADDRESS_BIT-1:0] h_waddr,
  output logic [ADDRESS_BIT-1:0] t_waddr,
  output logic [ADDRESS_BIT-1:0] n_waddr,
  output logic [ADDRESS_BIT-1:0] d_waddr,
  output logic [ADDRESS_BIT-1:0] h_wdata,
  output logic [ADDRESS_BIT-1:0] t_wdata,
  output logic [ADDRESS_BIT-1:0] n_wdata,
  output logic [DATA_BIT-1:0]    d_wdata,
  output logic [EXTRA_BIT-1:0]   e_wdata,
  output logic                   HCN,
  output logic                   O,
  output logic                   err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LINK = 3'd1;
  localparam logic [2:0] S_WH   = 3'd2;
  localparam logic [2:0] S_WN   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_NEW   = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_MERGE = 2'b10;

  localparam logic [ADDRESS_BIT:0] STEP_LIMIT = {1'b1, {ADDRESS_BIT{1'b0}}};

  function automatic logic [DATA_BIT-1:0] combine(input logic [DATA_BIT-1:0] a,
                                                   input logic [DATA_BIT-1:0] b);
    logic [X_BIT-1:0] axmin, axmax, bxmin, bxmax;
    logic [Y_BIT-1:0] aymin, aymax, bymin, bymax;
    {axmin, axmax, aymin, aymax} = a;
    {bxmin, bxmax, bymin, bymax} = b;
    return {(axmin < bxmin) ? axmin : bxmin,
            (axmax > bxmax) ? axmax : bxmax,
            (aymin < bymin) ? aymin : bymin,
            (aymax > bymax) ? aymax : bymax};
  endfunction

  function automatic logic [EXTRA_BIT-1:0] sat_add(input logic [EXTRA_BIT-1:0] a,
                                                   input logic [EXTRA_BIT-1:0] b);
    logic [EXTRA_BIT:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[EXTRA_BIT] ? {EXTRA_BIT{1'b1}} : s[EXTRA_BIT-1:0];
  endfunction

  logic [2:0]             state_q, state_d;
  logic [ADDRESS_BIT-1:0] cur_q, cur_d;
  logic [ADDRESS_BIT-1:0] ha_q, ha_d;
  logic [ADDRESS_BIT:0]   step_q, step_d;
  logic                   err_q, err_d;
  logic                   o_q, o_d;
  logic                   h_we_q, h_we_d, t_we_q, t_we_d;
  logic                   n_we_q, n_we_d, d_we_q, d_we_d;
  logic [ADDRESS_BIT-1:0] h_waddr_q, h_waddr_d, t_waddr_q, t_waddr_d;
  logic [ADDRESS_BIT-1:0] n_waddr_q, n_waddr_d, d_waddr_q, d_waddr_d;
  logic [ADDRESS_BIT-1:0] h_wdata_q, h_wdata_d, t_wdata_q, t_wdata_d;
  logic [ADDRESS_BIT-1:0] n_wdata_q, n_wdata_d;
  logic [DATA_BIT-1:0]    d_wdata_q, d_wdata_d;
  logic [EXTRA_BIT-1:0]   e_wdata_q, e_wdata_d;
  logic [DATA_BIT-1:0]    w_bbox;
  logic [EXTRA_BIT-1:0]   w_extra;

  assign w_bbox  = combine(op_da, op_db);
  assign w_extra = sat_add(op_ea, op_eb);

  // Write registers are loaded with the writes of the state being entered,
  // so each state's writes appear during the cycle that state is occupied.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ha_d      = ha_q;
    step_d    = step_q;
    err_d     = err_q;
    o_d       = 1'b0;
    h_we_d    = 1'b0;
    t_we_d    = 1'b0;
    n_we_d    = 1'b0;
    d_we_d    = 1'b0;
    h_waddr_d = h_waddr_q;
    t_waddr_d = t_waddr_q;
    n_waddr_d = n_waddr_q;
    d_waddr_d = d_waddr_q;
    h_wdata_d = h_wdata_q;
    t_wdata_d = t_wdata_q;
    n_wdata_d = n_wdata_q;
    d_wdata_d = d_wdata_q;
    e_wdata_d = e_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_NEW: begin
              h_we_d    = 1'b1;
              t_we_d    = 1'b1;
              n_we_d    = 1'b1;
              d_we_d    = 1'b1;
              h_waddr_d = op_label;
              t_waddr_d = op_label;
              n_waddr_d = op_label;
              d_waddr_d = op_label;
              h_wdata_d = op_label;
              t_wdata_d = op_label;
              n_wdata_d = op_label;
              d_wdata_d = op_da;
              e_wdata_d = op_ea;
            end
            OP_ADD: begin
              d_we_d    = 1'b1;
              d_waddr_d = op_ha;
              d_wdata_d = w_bbox;
              e_wdata_d = w_extra;
            end
            OP_MERGE: begin
              d_we_d    = 1'b1;
              d_waddr_d = op_ha;
              d_wdata_d = w_bbox;
              e_wdata_d = w_extra;
              if (op_ha == op_hb) begin
                o_d = 1'b1;
              end else begin
                state_d   = S_LINK;
                cur_d     = op_hb;
                ha_d      = op_ha;
                step_d    = '0;
                n_we_d    = 1'b1;
                n_waddr_d = op_ta;
                n_wdata_d = op_hb;
                t_we_d    = 1'b1;
                t_waddr_d = op_ha;
                t_wdata_d = op_tb;
              end
            end
            default: ;
          endcase
        end
      end
      S_LINK: begin
        state_d   = S_WH;
        h_we_d    = 1'b1;
        h_waddr_d = cur_q;
        h_wdata_d = ha_q;
        step_d    = step_q + 1'b1;
      end
      S_WH: state_d = S_WN;
      S_WN: begin
        if (w_rdata == cur_q) begin
          state_d = S_DONE;
          o_d     = 1'b1;
        end else if (step_q == STEP_LIMIT) begin
          // Set B never terminated: treat it as a corrupt list and bail out.
          state_d = S_DONE;
          o_d     = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d   = S_WH;
          cur_d     = w_rdata;
          h_we_d    = 1'b1;
          h_waddr_d = w_rdata;
          h_wdata_d = ha_q;
          step_d    = step_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      ha_q      <= '0;
      step_q    <= '0;
      err_q     <= 1'b0;
      o_q       <= 1'b0;
      h_we_q    <= 1'b0;
      t_we_q    <= 1'b0;
      n_we_q    <= 1'b0;
      d_we_q    <= 1'b0;
      h_waddr_q <= '0;
      t_waddr_q <= '0;
      n_waddr_q <= '0;
      d_waddr_q <= '0;
      h_wdata_q <= '0;
      t_wdata_q <= '0;
      n_wdata_q <= '0;
      d_wdata_q <= '0;
      e_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      ha_q      <= ha_d;
      step_q    <= step_d;
      err_q     <= err_d;
      o_q       <= o_d;
      h_we_q    <= h_we_d;
      t_we_q    <= t_we_d;
      n_we_q    <= n_we_d;
      d_we_q    <= d_we_d;
      h_waddr_q <= h_waddr_d;
      t_waddr_q <= t_waddr_d;
      n_waddr_q <= n_waddr_d;
      d_waddr_q <= d_waddr_d;
      h_wdata_q <= h_wdata_d;
      t_wdata_q <= t_wdata_d;
      n_wdata_q <= n_wdata_d;
      d_wdata_q <= d_wdata_d;
      e_wdata_q <= e_wdata_d;
    end
  end

  assign op_ready = (state_q == S_IDLE);
  assign w_raddr  = cur_q;
  assign h_we     = h_we_q;
  assign t_we     = t_we_q;
  assign n_we     = n_we_q;
  assign d_we     = d_we_q;
  assign h_waddr  = h_waddr_q;
  assign t_waddr  = t_waddr_q;
  assign n_waddr  = n_waddr_q;
  assign d_waddr  = d_waddr_q;
  assign h_wdata  = h_wdata_q;
  assign t_wdata  = t_wdata_q;
  assign n_wdata  = n_wdata_q;
  assign d_wdata  = d_wdata_q;
  assign e_wdata  = e_wdata_q;
  assign HCN      = h_we_q;
  assign O        = o_q;
  assign err      = err_q;

endmodule
`default_nettype wire
